// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar echo emulator and its measuring block.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } sonar_state_e;

    localparam int unsigned DEF_CYC_PER_MM  = 290;
    localparam int unsigned DEF_TRIG_MIN    = 500;
    localparam int unsigned DEF_BURST_CYC   = 10000;
    localparam int unsigned DEF_HOLDOFF_CYC = 50000;
    localparam int unsigned DEF_TIMEOUT_CYC = 1900000;
    localparam int unsigned DEF_MAX_MM      = 4000;

    // True on the last cycle of a phase that lasts `limit` cycles; widened so limit=0 is safe.
    function automatic logic cnt_done(input logic [31:0] cnt, input logic [31:0] limit);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/sonar_echo_model_if.sv
// Trigger/echo signal bundle between a measuring block (master) and the echo model (slave).
interface sonar_echo_model_if;

    logic        trig;
    logic [15:0] dist_mm;
    logic        echo;
    logic        busy;
    logic        runt_err;
    logic        trig_ignored;

    modport master (
        output trig,
        output dist_mm,
        input  echo,
        input  busy,
        input  runt_err,
        input  trig_ignored
    );

    modport slave (
        input  trig,
        input  dist_mm,
        output echo,
        output busy,
        output runt_err,
        output trig_ignored
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sonar_echo_model.sv
// Ultrasonic ranging sensor emulator: accepts a trig pulse, waits out the burst, then
// produces an echo pulse whose width encodes the latched target distance.
module sonar_echo_model
    import sonar_pkg::*;
#(
    parameter int unsigned CYC_PER_MM  = DEF_CYC_PER_MM,
    parameter int unsigned TRIG_MIN    = DEF_TRIG_MIN,
    parameter int unsigned BURST_CYC   = DEF_BURST_CYC,
    parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned MAX_MM      = DEF_MAX_MM
) (
    input logic         clk,
    input logic         reset_n,
    sonar_echo_model_if.slave bus
);

    localparam logic [15:0] CPM16 = CYC_PER_MM[15:0];

    logic         w_trig_s;
    logic         w_rise;
    logic [31:0]  w_width;

    sonar_state_e r_state, w_state_d;
    logic [31:0]  r_cnt, w_cnt_d;
    logic [15:0]  r_dist_q, w_dist_d;
    logic         r_trig_prev;
    logic         r_echo, w_echo_d;
    logic         r_runt, w_runt_d;
    logic         r_ign, w_ign_d;

    sync2 u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .i_d    (bus.trig),
        .o_q    (w_trig_s)
    );

    assign w_rise = w_trig_s & ~r_trig_prev;

    // Full 16x16 product; zero or out-of-range distances report the no-target timeout.
    always_comb begin
        w_width = TIMEOUT_CYC;
        if ((r_dist_q != 16'd0) && (32'(r_dist_q) <= MAX_MM)) begin
            w_width = 32'(r_dist_q) * 32'(CPM16);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 32'd0;
            r_dist_q    <= 16'd0;
            r_trig_prev <= 1'b0;
            r_echo      <= 1'b0;
            r_runt      <= 1'b0;
            r_ign       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_dist_q    <= w_dist_d;
            r_trig_prev <= w_trig_s;
            r_echo      <= w_echo_d;
            r_runt      <= w_runt_d;
            r_ign       <= w_ign_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_dist_d  = r_dist_q;
        w_echo_d  = r_echo;
        w_runt_d  = 1'b0;
        w_ign_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_d = TRIG_HI;
                    w_cnt_d   = 32'd1;
                end
            end
            TRIG_HI: begin
                if (w_trig_s) begin
                    if (r_cnt < TRIG_MIN) w_cnt_d = r_cnt + 32'd1;
                end else if (r_cnt >= TRIG_MIN) begin
                    w_dist_d  = bus.dist_mm;
                    w_cnt_d   = 32'd0;
                    w_state_d = BURST;
                end else begin
                    w_runt_d  = 1'b1;
                    w_cnt_d   = 32'd0;
                    w_state_d = IDLE;
                end
            end
            BURST: begin
                w_ign_d = w_rise;
                if (r_cnt >= BURST_CYC) begin
                    w_echo_d  = 1'b1;
                    w_cnt_d   = 32'd0;
                    w_state_d = ECHO;
                end else begin
                    w_cnt_d = r_cnt + 32'd1;
                end
            end
            ECHO: begin
                w_ign_d = w_rise;
                if (cnt_done(r_cnt, w_width)) begin
                    w_echo_d  = 1'b0;
                    w_cnt_d   = 32'd0;
                    w_state_d = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
                end else begin
                    w_cnt_d = r_cnt + 32'd1;
                end
            end
            HOLDOFF: begin
                // A rise on the final holdoff edge is still reported as ignored.
                w_ign_d = w_rise;
                if (cnt_done(r_cnt, HOLDOFF_CYC)) begin
                    w_cnt_d   = 32'd0;
                    w_state_d = IDLE;
                end else begin
                    w_cnt_d = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = 32'd0;
                w_echo_d  = 1'b0;
            end
        endcase
    end

    assign bus.echo         = r_echo;
    assign bus.busy         = (r_state != IDLE);
    assign bus.runt_err     = r_runt;
    assign bus.trig_ignored = r_ign;

endmodule
